// File: rtl/dcache_wb_buffer.sv
// dcache_wb_buffer: in-order write-back queue for dirty-line evictions and uncached stores.
// It drains entries over an address/data cache-bus handshake and provides a RAW hazard lookup.
//
// state  | meaning
// S_IDLE | waiting for a queued entry and a free bus
// S_ADR  | presenting head address/size/len, waiting for bus_ready_i
// S_DAT  | streaming beats of the head entry, waiting for bus_data_ok_i per beat
module dcache_wb_buffer #(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid_i,
    output logic             push_ready_o,
    input  logic             push_line_i,
    input  logic [29:0]      push_addr_i,
    input  logic [3:0][31:0] push_data_i,
    input  logic [3:0]       push_strb_i,
    input  logic [1:0]       push_size_i,
    input  logic [27:0]      chk_addr_i,
    output logic             chk_hit_o,
    output logic             empty_o,
    input  logic             bus_busy_i,
    output logic             bus_busy_o,
    output logic             bus_valid_o,
    output logic [31:0]      bus_addr_o,
    output logic [1:0]       bus_size_o,
    output logic [1:0]       bus_len_o,
    input  logic             bus_ready_i,
    output logic [31:0]      bus_wdata_o,
    output logic [3:0]       bus_wstrb_o,
    output logic             bus_wlast_o,
    input  logic             bus_data_ok_i
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADR  = 2'd1,
        S_DAT  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [29:0]      r_addr [DEPTH];
    logic [3:0][31:0] r_data [DEPTH];
    logic [3:0]       r_strb [DEPTH];
    logic [1:0]       r_size [DEPTH];
    logic [DEPTH-1:0] r_line;
    logic [DEPTH-1:0] r_vld;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [1:0]       r_beat;

    logic             w_push;
    logic             w_pop;
    logic             w_last_beat;
    logic [1:0]       w_len;
    logic             w_hit;

    assign push_ready_o = (r_count < DEPTH_C);
    assign w_push       = push_valid_i && push_ready_o;
    assign w_len        = r_line[r_rd_ptr] ? 2'd3 : 2'd0;
    assign w_last_beat  = (r_beat == w_len);
    // The head is released only after its final beat, so the hazard check covers it until then.
    assign w_pop        = (r_state == S_DAT) && bus_data_ok_i && w_last_beat;

    // Payload fields carry no reset; r_vld alone says whether a slot is live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wr_ptr] <= push_line_i ? {push_addr_i[29:2], 2'b00} : push_addr_i;
            r_data[r_wr_ptr] <= push_data_i;
            r_strb[r_wr_ptr] <= push_line_i ? 4'hF : push_strb_i;
            r_size[r_wr_ptr] <= push_line_i ? 2'b10 : push_size_i;
            r_line[r_wr_ptr] <= push_line_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_vld    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
            if (w_pop) begin
                r_vld[r_rd_ptr] <= 1'b0;
            end
            if (w_push) begin
                r_vld[r_wr_ptr] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if ((r_count != '0) && !bus_busy_i) begin
                    w_state_nxt = S_ADR;
                end
            end
            S_ADR: begin
                if (bus_ready_i) begin
                    w_state_nxt = S_DAT;
                end
            end
            S_DAT: begin
                if (bus_data_ok_i && w_last_beat) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat <= '0;
        end else if ((r_state == S_ADR) && bus_ready_i) begin
            r_beat <= '0;
        end else if ((r_state == S_DAT) && bus_data_ok_i) begin
            r_beat <= w_last_beat ? 2'd0 : r_beat + 2'd1;
        end
    end

    always_comb begin
        bus_valid_o = 1'b0;
        bus_busy_o  = 1'b0;
        bus_addr_o  = '0;
        bus_size_o  = '0;
        bus_len_o   = '0;
        bus_wdata_o = '0;
        bus_wstrb_o = '0;
        bus_wlast_o = 1'b0;
        case (r_state)
            S_ADR: begin
                bus_valid_o = 1'b1;
                bus_busy_o  = 1'b1;
                bus_addr_o  = {r_addr[r_rd_ptr], 2'b00};
                bus_size_o  = r_size[r_rd_ptr];
                bus_len_o   = w_len;
            end
            S_DAT: begin
                bus_busy_o  = 1'b1;
                bus_wdata_o = r_data[r_rd_ptr][r_beat];
                bus_wstrb_o = r_strb[r_rd_ptr];
                bus_wlast_o = w_last_beat;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && (r_addr[i][29:2] == chk_addr_i)) begin
                w_hit = 1'b1;
            end
        end
    end

    assign chk_hit_o = w_hit;
    assign empty_o   = (r_count == '0) && (r_state == S_IDLE);

endmodule
